// File: rtl/serial_word_feeder.sv
// serial_word_feeder
// Accepts a parallel word while idle, pulses a clear to the downstream
// residue detector, streams the word MSB first with its bit index, and
// pulses done once the last bit has been sent. All outputs are registered.
module serial_word_feeder #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     ready,
    output logic                     det_reset,
    output logic                     ser_out,
    output logic                     ser_valid,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_ready;
    logic             r_det_reset;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic [CW-1:0]    r_bit_idx;
    logic             r_done;

    // State, datapath and registered outputs, all updated together so every
    // output reflects the state it is registered alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_ready     <= 1'b1;
            r_det_reset <= 1'b0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_bit_idx   <= '0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_det_reset <= 1'b0;
                    r_ser_out   <= 1'b0;
                    r_ser_valid <= 1'b0;
                    r_bit_idx   <= '0;
                    r_done      <= 1'b0;
                    if (load) begin
                        r_shift     <= data_in;
                        r_cnt       <= CW'(WIDTH - 1);
                        r_state     <= ST_CLEAR;
                        r_ready     <= 1'b0;
                        r_det_reset <= 1'b1;
                    end else begin
                        r_ready     <= 1'b1;
                    end
                end

                ST_CLEAR: begin
                    // First bit is presented straight from the captured word.
                    r_state     <= ST_SHIFT;
                    r_det_reset <= 1'b0;
                    r_ready     <= 1'b0;
                    r_ser_valid <= 1'b1;
                    r_ser_out   <= r_shift[WIDTH-1];
                    r_bit_idx   <= r_cnt;
                    r_done      <= 1'b0;
                end

                ST_SHIFT: begin
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    if (r_cnt == '0) begin
                        r_state     <= ST_DONE;
                        r_ser_valid <= 1'b0;
                        r_ser_out   <= 1'b0;
                        r_bit_idx   <= '0;
                        r_done      <= 1'b1;
                    end else begin
                        // Outputs track the post-shift MSB and counter.
                        r_cnt       <= r_cnt - 1'b1;
                        r_ser_valid <= 1'b1;
                        r_ser_out   <= r_shift[WIDTH-2];
                        r_bit_idx   <= r_cnt - 1'b1;
                        r_done      <= 1'b0;
                    end
                    r_ready     <= 1'b0;
                    r_det_reset <= 1'b0;
                end

                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_ready     <= 1'b1;
                    r_done      <= 1'b0;
                    r_det_reset <= 1'b0;
                    r_ser_valid <= 1'b0;
                    r_ser_out   <= 1'b0;
                    r_bit_idx   <= '0;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_shift     <= '0;
                    r_cnt       <= '0;
                    r_ready     <= 1'b1;
                    r_det_reset <= 1'b0;
                    r_ser_out   <= 1'b0;
                    r_ser_valid <= 1'b0;
                    r_bit_idx   <= '0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign det_reset = r_det_reset;
    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign bit_idx   = r_bit_idx;
    assign done      = r_done;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Testbench for serial_word_feeder: frame-queue model for WIDTH=8 checked
// every cycle, directed scenarios with literal expectations, and a WIDTH=4
// instance for the narrow build.
module tb_serial_word_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       reset, load;
    logic [7:0] data_in;
    logic       ready, det_reset, ser_out, ser_valid, done;
    logic [2:0] bit_idx;

    serial_word_feeder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in),
        .ready(ready), .det_reset(det_reset), .ser_out(ser_out),
        .ser_valid(ser_valid), .bit_idx(bit_idx), .done(done)
    );

    // WIDTH=4 instance
    logic       reset4, load4;
    logic [3:0] data4;
    logic       ready4, det4, ser4, valid4, done4;
    logic [1:0] idx4;

    serial_word_feeder #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset4), .load(load4), .data_in(data4),
        .ready(ready4), .det_reset(det4), .ser_out(ser4),
        .ser_valid(valid4), .bit_idx(idx4), .done(done4)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Model: a word becomes a list of output frames {ready,det,valid,ser,idx,done}
    typedef struct packed {
        logic       rdy;
        logic       det;
        logic       vld;
        logic       ser;
        logic [2:0] idx;
        logic       dn;
    } frame_t;

    localparam frame_t IDLE_F = '{rdy: 1'b1, det: 1'b0, vld: 1'b0, ser: 1'b0, idx: 3'd0, dn: 1'b0};

    frame_t mq[$];
    frame_t mcur;
    bit     m_ok = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            mcur = IDLE_F;
            m_ok = 1'b1;
        end else if (m_ok) begin
            if (mcur.rdy && load) begin
                mq.delete();
                mq.push_back('{rdy: 1'b0, det: 1'b1, vld: 1'b0, ser: 1'b0, idx: 3'd0, dn: 1'b0});
                for (int i = 7; i >= 0; i--)
                    mq.push_back('{rdy: 1'b0, det: 1'b0, vld: 1'b1, ser: data_in[i], idx: 3'(i), dn: 1'b0});
                mq.push_back('{rdy: 1'b0, det: 1'b0, vld: 1'b0, ser: 1'b0, idx: 3'd0, dn: 1'b1});
                mcur = mq.pop_front();
            end else if (mq.size() > 0) begin
                mcur = mq.pop_front();
            end else begin
                mcur = IDLE_F;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok)
            check("cycle_outputs", {ready, det_reset, ser_valid, ser_out, bit_idx, done}, mcur);
    end

    // Observers for WIDTH=8: det spacing, collected words, residue-mod-3 detector
    int         cyc8 = 0;
    int         det_cnt8 = 0;
    int         last_det_cyc = -100;
    int         det_gap = 0;
    int         done_cnt8 = 0;
    logic [7:0] bits8 = '0;
    int         nbits8 = 0;
    int         res3 = 0;
    logic       res_at_done = 1'b0;
    logic [7:0] done_words[$];

    always @(negedge clk) begin
        cyc8++;
        if (det_reset) begin
            det_gap      = cyc8 - last_det_cyc;
            last_det_cyc = cyc8;
            det_cnt8++;
            bits8  = '0;
            nbits8 = 0;
            res3   = 0;
        end
        if (ser_valid) begin
            bits8 = {bits8[6:0], ser_out};
            nbits8++;
            res3 = (res3 * 2 + int'(ser_out)) % 3;
        end
        if (done) begin
            done_cnt8++;
            done_words.push_back(bits8);
            res_at_done = (res3 == 0);
        end
    end

    // Observers for WIDTH=4
    logic [3:0] bits4 = '0;
    int         exp_idx4 = 0;
    int         idx4_bad = 0;
    int         done_cnt4 = 0;

    always @(negedge clk) begin
        if (det4) begin
            bits4    = '0;
            exp_idx4 = 3;
        end
        if (valid4) begin
            bits4 = {bits4[2:0], ser4};
            if (int'(idx4) != exp_idx4) idx4_bad++;
            exp_idx4--;
        end
        if (done4) done_cnt4++;
    end

    task automatic wait_done_to(input int target);
        for (int i = 0; i < 40 && done_cnt8 < target; i++) step();
        check("done_reached", done_cnt8, target);
    endtask

    task automatic send8(input logic [7:0] w);
        load    = 1'b1;
        data_in = w;
        step();
        load    = 1'b0;
        data_in = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        int dc;
        int n;
        logic [7:0] rwords [4];
        logic       rexp   [4];

        reset = 1'b1; load = 1'b0; data_in = '0;
        reset4 = 1'b1; load4 = 1'b0; data4 = '0;
        step(); step();
        reset = 1'b0; reset4 = 1'b0;
        step();

        // Reset state
        check("reset_ready", ready, 1);
        check("reset_outs", {det_reset, ser_valid, ser_out, bit_idx, done}, 0);
        check("reset4_ready", ready4, 1);

        // Single word 8'b1000_0001
        d0 = done_cnt8;
        send8(8'h81);
        check("s1_det", det_reset, 1);
        check("s1_not_ready", ready, 0);
        wait_done_to(d0 + 1);
        check("s1_word", done_words[done_words.size()-1], 8'h81);
        step();
        check("s1_ready_after", ready, 1);

        // Back-to-back with load held high; data_in changes mid-shift
        d0 = done_cnt8;
        dc = det_cnt8;
        load = 1'b1; data_in = 8'hFF;
        step();
        data_in = 8'h03;
        for (int i = 0; i < 40 && det_cnt8 < dc + 2; i++) step();
        load = 1'b0;
        check("b2b_two_accepts", det_cnt8 - dc, 2);
        check("b2b_spacing", det_gap, 11);
        wait_done_to(d0 + 2);
        check("b2b_word1", done_words[done_words.size()-2], 8'hFF);
        check("b2b_word2", done_words[done_words.size()-1], 8'h03);
        step();

        // Reset during the 4th SHIFT cycle of 8'hA5
        d0 = done_cnt8;
        send8(8'hA5);
        step(); step(); step(); step();
        check("abort_in_shift", {ser_valid, 4'(nbits8)}, {1'b1, 4'd4});
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_valid", ser_valid, 0);
        check("abort_ready", ready, 1);
        step(); step(); step();
        check("abort_no_done", done_cnt8, d0);
        send8(8'h0C);
        check("abort_new_det", det_reset, 1);
        wait_done_to(d0 + 1);
        check("abort_new_word", done_words[done_words.size()-1], 8'h0C);
        step();

        // load coincident with reset in IDLE
        dc = det_cnt8;
        reset = 1'b1; load = 1'b1; data_in = 8'hFF;
        step();
        reset = 1'b0; load = 1'b0; data_in = '0;
        check("rl_ready", ready, 1);
        check("rl_outs", {det_reset, ser_valid, ser_out, done}, 0);
        step();
        check("rl_no_det", det_cnt8 - dc, 0);
        check("rl_ready2", ready, 1);

        // Residue detector integration
        rwords = '{8'd0, 8'd3, 8'd7, 8'd255};
        rexp   = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            d0 = done_cnt8;
            send8(rwords[k]);
            wait_done_to(d0 + 1);
            check($sformatf("residue_word_%0d", rwords[k]), res_at_done, rexp[k]);
            step();
        end

        // WIDTH=4 build: 4'b0110
        load4 = 1'b1; data4 = 4'b0110;
        step();
        load4 = 1'b0; data4 = '0;
        check("w4_det", det4, 1);
        n = 0;
        while (!ready4 && n < 20) begin
            step();
            n++;
        end
        check("w4_cycles", n, 6);
        check("w4_bits", bits4, 4'b0110);
        check("w4_idx_errors", idx4_bad, 0);
        check("w4_done_count", done_cnt4, 1);

        step(); step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_word_feeder.md
SERIAL_WORD_FEEDER -- requirements
Module: serial_word_feeder

Interface
REQ-001 Parameter: WIDTH, default 8, number of bits per word (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 load  input  1  request to accept data_in; effective only when ready=1.
REQ-005 data_in  input  WIDTH  parallel word to serialize.
REQ-006 ready  output  1  feeder idle and able to accept a word.
REQ-007 det_reset  output  1  one-cycle clear pulse for the downstream residue detector.
REQ-008 ser_out  output  1  current serial bit, MSB first.
REQ-009 ser_valid  output  1  ser_out carries a valid word bit this cycle.
REQ-010 bit_idx  output  $clog2(WIDTH)  index of the bit on ser_out (WIDTH-1 down to 0).
REQ-011 done  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-012 FSM states SHALL be IDLE, CLEAR, SHIFT, DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-013 IDLE: ready=1, det_reset=0, ser_valid=0, ser_out=0, done=0.
REQ-014 IDLE and load=1 at a posedge: capture data_in into the shift register, load the bit counter with WIDTH-1, go to CLEAR.
REQ-015 load=1 in any state other than IDLE SHALL be ignored; data_in is sampled only on the accepting edge.
REQ-016 CLEAR lasts exactly one cycle: det_reset=1, ready=0, ser_valid=0; then go to SHIFT.
REQ-017 SHIFT lasts exactly WIDTH cycles: ser_valid=1, ser_out = shift-register MSB, bit_idx = counter; each posedge shifts left by one and decrements the counter.
REQ-018 SHIFT with counter=0 at a posedge: go to DONE; the counter SHALL NOT wrap below 0.
REQ-019 DONE lasts exactly one cycle: done=1, ser_valid=0, ready=0; then go to IDLE.
REQ-020 Latency: accept edge to first valid bit = 2 cycles (CLEAR, then SHIFT); accept to done = WIDTH+1 cycles after CLEAR; back-to-back words SHALL be spaced WIDTH+3 cycles apart (load held high).
REQ-021 ser_out and bit_idx SHALL be 0 whenever ser_valid=0.
REQ-022 The stream SHALL have no gaps: bits of one word appear on WIDTH consecutive cycles with ser_valid=1.
REQ-023 Unreachable state encodings SHALL return to IDLE on the next edge with all outputs at their IDLE values.

Reset
REQ-024 reset=1 at a posedge SHALL force IDLE, clear the shift register and counter, and drive det_reset=0, ser_valid=0, ser_out=0, bit_idx=0, done=0, with ready=1 after that edge.
REQ-025 reset SHALL take priority over load; a load coincident with reset SHALL be dropped.
REQ-026 reset mid-word (CLEAR, SHIFT or DONE) SHALL abort the word with no done pulse; the next accepted word SHALL again start with CLEAR.

Verification
REQ-027 WIDTH=8, load data_in=8'b1000_0001 from IDLE -> det_reset high 1 cycle, then ser_out 1,0,0,0,0,0,0,1 with bit_idx 7..0, then done high 1 cycle, then ready=1.
REQ-028 load held high continuously with 8'hFF then 8'h03 presented -> second word accepted exactly 11 cycles after the first; data_in changes during SHIFT do not alter the bits.
REQ-029 reset asserted on the 4th SHIFT cycle of 8'hA5 -> next cycle ser_valid=0, done never pulses, ready=1; a new load of 8'h0C produces det_reset then 0,0,0,0,1,1,0,0.
REQ-030 load and reset both high in IDLE -> no det_reset, ready stays 1, outputs stay 0.
REQ-031 WIDTH=4 build, load 4'b0110 -> CLEAR, bits 0,1,1,0, done; total 6 cycles from accept edge to return to IDLE.
REQ-032 Integration: feeder drives the residue detector (det_reset to its reset, ser_out to its input) with words 8'd0, 8'd3, 8'd7, 8'd255 -> detector's final out = 1, 1, 0, 1 respectively.
